video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised pixel-clock video timing generator with an integrated colour expander; successor to the fixed 640x480 VGA sync path feeding the DVI encoder.
- Generates hsync/vsync/blank plus per-pixel coordinate requests to the framebuffer, and accepts colour LATENCY clocks after each request.
- Expands N-bit-per-channel colour to RGB888 and delays all sync signals so they are aligned with the colour at the outputs.
- Sits between the display controller and hdmi_interface in the clk_pixel domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
IN_BITS, 2, input bits per colour channel, legal range 1..8
LATENCY, 1, clocks from req to valid in_r/g/b, legal range 1..4

Ports:
clk_pixel  in  1  pixel clock
reset  in  1  synchronous, active-high reset
req  out  1  pixel request; high while the coordinate is in the active area
x  out  12  requested column, 0..H_ACTIVE-1, valid with req
y  out  12  requested row, 0..V_ACTIVE-1, valid with req
frame_start  out  1  one-clock pulse at hcnt=0, vcnt=0
in_r  in  IN_BITS  red, sampled LATENCY clocks after req
in_g  in  IN_BITS  green
in_b  in  IN_BITS  blue
red  out  8  expanded red
green  out  8  expanded green
blue  out  8  expanded blue
hsync  out  1  aligned horizontal sync
vsync  out  1  aligned vertical sync
blank  out  1  aligned blanking (1 = outside active area)

Behaviour:
- Clocking and reset: one clock, clk_pixel. reset is synchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters:
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps; after V_TOTAL-1 it wraps to 0.
- Region decode (stage 0, registered):
  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs_raw = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_raw = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Stage 0 outputs:
  - req = active.
  - x = hcnt and y = vcnt, zero-extended to 12 bits. When req=0, x and y still reflect the counters.
  - frame_start = (hcnt==0 && vcnt==0).
- Input sampling: in_r/g/b are sampled exactly LATENCY clocks after the req cycle of the same pixel. Sampled colour is forced to 0 when the delayed active bit is 0.
- Expansion (registered):
  - out bit [7-i] = in[IN_BITS-1-(i mod IN_BITS)], for i=0..7 (cyclic MSB-first replication).
  - IN_BITS=8 is a pass-through.
- Output alignment:
  - hs_raw, vs_raw and active pass through a LATENCY+1 stage shift register.
  - hsync = delayed hs_raw XNOR H_POL; vsync likewise with V_POL.
  - blank = ~delayed active.
  - Total req-to-output latency is LATENCY+1 clocks for colour and sync alike.
- Reset values:
  - hcnt=vcnt=0; all delay stages cleared to "inactive".
  - req=0, frame_start=0, x=y=0.
  - red=green=blue=0, blank=1, hsync=~H_POL, vsync=~V_POL.
- First clock after reset deasserts: counters at 0,0, so req=1 and frame_start=1 on the next registered edge.
- Reset asserted mid-frame: takes effect on the next edge. Pipeline contents are discarded, with no partial pixels emitted.
- Simultaneous wraps: on the clock where hcnt and vcnt both wrap, the next cycle is hcnt=0, vcnt=0 with frame_start=1.
- Parameter violations (IN_BITS or LATENCY out of range, total >4095) are compile-time errors, raised by a generate-time check.

Optional Feature:
- Macro: VTG_TEST_PATTERN_EN.
- When defined:
  - Adds input test_en (1 bit).
  - When test_en=1, the sampled input colour is replaced by 8 vertical colour bars. Bar index = x*8/H_ACTIVE, computed at stage 0 and delayed LATENCY.
  - Bar k colour: red=k[2], green=k[1], blue=k[0], each full scale (8'hFF) or 0.
  - Bypasses the expander while keeping the same latency.
- When undefined: port absent, no pattern logic.

Test Plan:
- Reset, then release with default parameters: first edge gives req=1, x=0, y=0, frame_start=1. During reset, blank=1, hsync=1, vsync=1, rgb=0.
- Free run for 2 frames:
  - hsync low for exactly 96 clocks per 800-clock line, starting 656 clocks after line start (plus latency).
  - vsync low for 2 lines out of 525.
  - frame_start period is 420000 clocks.
- IN_BITS=2, LATENCY=1: drive in_r=2'b10 one clock after req at x=5 → red=8'b10101010 two clocks after req, with blank=0. With in_g=2'b01 → 8'b01010101.
- IN_BITS=3, LATENCY=3: in_b=3'b101 → blue=8'b10110110. blank, hsync and rgb all change on the same edge, LATENCY+1=4 clocks after the req transition.
- Assert reset at hcnt=300, vcnt=100 for 1 clock → next edge returns to x=0, y=0 with all outputs at reset values, and no stale pixel appears at the outputs.
- With VTG_TEST_PATTERN_EN, test_en=1, H_ACTIVE=640: x=0 → rgb 000000; x=80 → 0000FF; x=639 → FFFFFF; blanking region → 0.

Source files
------------

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Pixel-clock video timing generator with an integrated colour expander.
//   Stage 0 decodes the raster counters into req/x/y/frame_start for the
//   framebuffer. Colour returns LATENCY clocks later and is widened to RGB888.
//   The sync and blank signals are delayed by LATENCY+1 clocks so that they
//   leave the block on the same edge as the colour of the same pixel.
//
// Ports
//   clk_pixel          pixel clock
//   reset              synchronous, active-high reset
//   test_en            (VTG_TEST_PATTERN_EN only) replace colour with 8 bars
//   req, x, y          pixel request and coordinate (stage 0)
//   frame_start        one-clock pulse at hcnt=0, vcnt=0 (stage 0)
//   in_r, in_g, in_b   IN_BITS-per-channel colour, LATENCY clocks after req
//   red, green, blue   expanded 8-bit colour
//   hsync, vsync       polarity-adjusted syncs, aligned with colour
//   blank              1 outside the active area, aligned with colour
//
// Optional feature macro: VTG_TEST_PATTERN_EN (vertical colour-bar generator)
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int IN_BITS  = 2,
  parameter int LATENCY  = 1
) (
  input  logic               clk_pixel,
  input  logic               reset,
`ifdef VTG_TEST_PATTERN_EN
  input  logic               test_en,
`endif
  output logic               req,
  output logic [11:0]        x,
  output logic [11:0]        y,
  output logic               frame_start,
  input  logic [IN_BITS-1:0] in_r,
  input  logic [IN_BITS-1:0] in_g,
  input  logic [IN_BITS-1:0] in_b,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               hsync,
  output logic               vsync,
  output logic               blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  // Elaboration-time parameter guards.
  generate
    if (IN_BITS < 1 || IN_BITS > 8) begin : g_bad_in_bits
      $error("video_timing_gen: IN_BITS must be in 1..8");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("video_timing_gen: LATENCY must be in 1..4");
    end
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 4095");
    end
  endgenerate

  // Cyclic MSB-first replication; IN_BITS=8 degenerates to a pass-through.
  function automatic logic [7:0] expand(input logic [IN_BITS-1:0] c);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) begin
      o[7-i] = c[IN_BITS-1-(i % IN_BITS)];
    end
    return o;
  endfunction

  logic [11:0] hcnt, vcnt;
  logic        active_c, hs_c, vs_c;
  logic        hs0, vs0;
  logic [LATENCY:0] act_sr, hs_sr, vs_sr;
  logic [7:0]  red_nxt, green_nxt, blue_nxt;

  // Raster counters.
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge value of its sources, independent of block order.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 12'd1;
    end else begin
      hcnt <= hcnt + 12'd1;
    end
  end

  assign active_c = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_c     = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_c     = (vcnt >= VS_BEG) && (vcnt < VS_END);

  // Stage 0: framebuffer request. req doubles as the stage-0 active bit.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      req         <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      hs0         <= 1'b0;
      vs0         <= 1'b0;
    end else begin
      req         <= active_c;
      x           <= hcnt;
      y           <= vcnt;
      frame_start <= (hcnt == '0) && (vcnt == '0);
      hs0         <= hs_c;
      vs0         <= vs_c;
    end
  end

  // Alignment shift registers: bit k holds the stage-0 value from k+1 clocks
  // ago, so bit LATENCY-1 is the pixel whose colour is on in_* right now and
  // bit LATENCY is the pixel currently on the outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      act_sr <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
    end else begin
      act_sr <= {act_sr[LATENCY-1:0], req};
      hs_sr  <= {hs_sr[LATENCY-1:0],  hs0};
      vs_sr  <= {vs_sr[LATENCY-1:0],  vs0};
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  logic [2:0] bar0;
  logic [2:0] bar_sr [LATENCY];

  // NOTE: the bar-index pipeline has no reset; its contents are only used
  // when the matching active bit (which is reset) is set.
  always_ff @(posedge clk_pixel) begin
    bar0      <= 3'((int'(hcnt) * 8) / H_ACTIVE);
    bar_sr[0] <= bar0;
    for (int i = 1; i < LATENCY; i++) begin
      bar_sr[i] <= bar_sr[i-1];
    end
  end
`endif

  // Colour select: inactive pixels are forced to black so nothing sampled
  // during blanking can leak to the outputs.
  always_comb begin
    // NOTE: defaults first so every path assigns each output -- no latches.
    red_nxt   = '0;
    green_nxt = '0;
    blue_nxt  = '0;
    if (act_sr[LATENCY-1]) begin
      red_nxt   = expand(in_r);
      green_nxt = expand(in_g);
      blue_nxt  = expand(in_b);
`ifdef VTG_TEST_PATTERN_EN
      if (test_en) begin
        red_nxt   = {8{bar_sr[LATENCY-1][2]}};
        green_nxt = {8{bar_sr[LATENCY-1][1]}};
        blue_nxt  = {8{bar_sr[LATENCY-1][0]}};
      end
`endif
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= red_nxt;
      green <= green_nxt;
      blue  <= blue_nxt;
    end
  end

  // Cleared stages read as "not in sync", giving the inactive level ~POL.
  assign hsync = ~(hs_sr[LATENCY] ^ H_POL);
  assign vsync = ~(vs_sr[LATENCY] ^ V_POL);
  assign blank = ~act_sr[LATENCY];

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//   Two instances on a shrunken raster (24x10 clocks per frame):
//     dut_a: IN_BITS=2, LATENCY=1, active-low syncs
//     dut_b: IN_BITS=3, LATENCY=3, active-high syncs
//   A driver walks its own raster model, acts as the framebuffer for both
//   instances and pushes the expected stage-0 and output records into
//   queues; a monitor pops and compares one record per clock.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 24
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  // Hand-expanded colour tables.
  localparam logic [7:0] EXP2 [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};
  localparam logic [7:0] EXP3 [8] = '{8'h00, 8'h24, 8'h49, 8'h6D,
                                      8'h92, 8'hB6, 8'hDB, 8'hFF};

  typedef struct packed {
    logic        req;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } s0_t;

  typedef struct packed {
    logic       blank;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } out_t;

  typedef struct {
    int h;
    int v;
  } coord_t;

  localparam s0_t  IDLE_S0    = '{req: 1'b0, fs: 1'b0, x: 12'd0, y: 12'd0};
  localparam out_t IDLE_OUT_A = '{blank: 1'b1, hs: 1'b1, vs: 1'b1, r: 8'h00, g: 8'h00, b: 8'h00};
  localparam out_t IDLE_OUT_B = '{blank: 1'b1, hs: 1'b0, vs: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;
  logic pat_on    = 1'b0;
  logic mon_en    = 1'b0;

  logic [1:0]  ra = '1, ga = '1, ba = '1;
  logic [2:0]  rb = '1, gb = '1, bb = '1;
  logic        req_a, fs_a, hsync_a, vsync_a, blank_a;
  logic        req_b, fs_b, hsync_b, vsync_b, blank_b;
  logic [11:0] x_a, y_a, x_b, y_b;
  logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;

  int n_checks = 0;
  int n_errors = 0;
  int mh = 0, mv = 0;
  int cyc = 0, last_fs = -1, hlow = 0, vlow = 0;

  s0_t    s0q_a[$], s0q_b[$];
  out_t   oq_a[$], oq_b[$];
  coord_t hist_a[$], hist_b[$];

  always #5 clk_pixel = ~clk_pixel;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .IN_BITS(2), .LATENCY(LAT_A)
  ) dut_a (
    .clk_pixel(clk_pixel), .reset(reset),
`ifdef VTG_TEST_PATTERN_EN
    .test_en(pat_on),
`endif
    .req(req_a), .x(x_a), .y(y_a), .frame_start(fs_a),
    .in_r(ra), .in_g(ga), .in_b(ba),
    .red(red_a), .green(green_a), .blue(blue_a),
    .hsync(hsync_a), .vsync(vsync_a), .blank(blank_a)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .IN_BITS(3), .LATENCY(LAT_B)
  ) dut_b (
    .clk_pixel(clk_pixel), .reset(reset),
`ifdef VTG_TEST_PATTERN_EN
    .test_en(pat_on),
`endif
    .req(req_b), .x(x_b), .y(y_b), .frame_start(fs_b),
    .in_r(rb), .in_g(gb), .in_b(bb),
    .red(red_b), .green(green_b), .blue(blue_b),
    .hsync(hsync_b), .vsync(vsync_b), .blank(blank_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_active(input int h, input int v);
    return (h < HA) && (v < VA);
  endfunction

  // Framebuffer contents: a 3-bit value per pixel.
  function automatic logic [2:0] pix_val(input int h, input int v);
    return 3'((h + 2 * v) % 8);
  endfunction

  function automatic s0_t s0_exp(input int h, input int v);
    s0_t e;
    e.req = is_active(h, v);
    e.fs  = (h == 0) && (v == 0);
    e.x   = 12'(h);
    e.y   = 12'(v);
    return e;
  endfunction

  function automatic out_t out_exp(input int h, input int v, input bit cfg_b, input bit pat);
    out_t       e;
    logic [2:0] val, k, vi, vx;
    logic [1:0] v2, v2i, v2x;
    bit         in_hs, in_vs;
    in_hs   = (h >= HA + HF) && (h < HA + HF + HS);
    in_vs   = (v >= VA + VF) && (v < VA + VF + VS);
    e.blank = !is_active(h, v);
    e.hs    = in_hs ? cfg_b : !cfg_b;
    e.vs    = in_vs ? cfg_b : !cfg_b;
    e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
    if (is_active(h, v)) begin
      if (pat) begin
        k   = 3'((h * 8) / HA);
        e.r = k[2] ? 8'hFF : 8'h00;
        e.g = k[1] ? 8'hFF : 8'h00;
        e.b = k[0] ? 8'hFF : 8'h00;
      end else if (cfg_b) begin
        val = pix_val(h, v);
        vi  = ~val;
        vx  = val ^ 3'b101;
        e.r = EXP3[val]; e.g = EXP3[vi]; e.b = EXP3[vx];
      end else begin
        val = pix_val(h, v);
        v2  = val[1:0];
        v2i = ~v2;
        v2x = v2 ^ 2'b01;
        e.r = EXP2[v2]; e.g = EXP2[v2i]; e.b = EXP2[v2x];
      end
    end
    return e;
  endfunction

  // Drive one clock of stimulus at a negedge, then wait for the next one.
  // Colour for a pixel is driven LATENCY+1 negedges after its coordinate was
  // pushed, i.e. during the LATENCY-th clock after its req cycle.
  task automatic step();
    coord_t     c, p;
    logic [2:0] val;
    c.h = mh;
    c.v = mv;
    s0q_a.push_back(s0_exp(mh, mv));
    s0q_b.push_back(s0_exp(mh, mv));
    hist_a.push_back(c);
    hist_b.push_back(c);
    ra = '1; ga = '1; ba = '1;
    rb = '1; gb = '1; bb = '1;
    if (hist_a.size() > LAT_A + 1) begin
      p = hist_a.pop_front();
      if (is_active(p.h, p.v)) begin
        val = pix_val(p.h, p.v);
        ra = val[1:0]; ga = ~val[1:0]; ba = val[1:0] ^ 2'b01;
      end
      oq_a.push_back(out_exp(p.h, p.v, 1'b0, pat_on));
    end
    if (hist_b.size() > LAT_B + 1) begin
      p = hist_b.pop_front();
      if (is_active(p.h, p.v)) begin
        val = pix_val(p.h, p.v);
        rb = val; gb = ~val; bb = val ^ 3'b101;
      end
      oq_b.push_back(out_exp(p.h, p.v, 1'b1, pat_on));
    end
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
    @(negedge clk_pixel);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    hist_a.delete();
    hist_b.delete();
    repeat (n) @(negedge clk_pixel);
    reset = 1'b0;
    mh = 0;
    mv = 0;
  endtask

  // Monitor: one record per DUT per clock, sampled 1 time unit after the edge.
  always @(posedge clk_pixel) begin
    s0_t  g0;
    out_t go;
    #1;
    if (mon_en) begin
      cyc++;
      g0 = '{req: req_a, fs: fs_a, x: x_a, y: y_a};
      if (s0q_a.size() > 0) check("a_stage0", 32'(g0), 32'(s0q_a.pop_front()));
      else                  check("a_stage0_idle", 32'(g0), 32'(IDLE_S0));
      g0 = '{req: req_b, fs: fs_b, x: x_b, y: y_b};
      if (s0q_b.size() > 0) check("b_stage0", 32'(g0), 32'(s0q_b.pop_front()));
      else                  check("b_stage0_idle", 32'(g0), 32'(IDLE_S0));
      go = '{blank: blank_a, hs: hsync_a, vs: vsync_a, r: red_a, g: green_a, b: blue_a};
      if (oq_a.size() > 0) check("a_out", 32'(go), 32'(oq_a.pop_front()));
      else                 check("a_out_idle", 32'(go), 32'(IDLE_OUT_A));
      go = '{blank: blank_b, hs: hsync_b, vs: vsync_b, r: red_b, g: green_b, b: blue_b};
      if (oq_b.size() > 0) check("b_out", 32'(go), 32'(oq_b.pop_front()));
      else                 check("b_out_idle", 32'(go), 32'(IDLE_OUT_B));

      // Pulse widths and frame period on dut_a.
      if (reset) begin
        hlow    = 0;
        vlow    = 0;
        last_fs = -1;
      end else begin
        if (!hsync_a) hlow++;
        else if (hlow > 0) begin
          check("a_hsync_width", 32'(hlow), 32'(HS));
          hlow = 0;
        end
        if (!vsync_a) vlow++;
        else if (vlow > 0) begin
          check("a_vsync_width", 32'(vlow), 32'(VS * HT));
          vlow = 0;
        end
        if (fs_a) begin
          if (last_fs >= 0) check("a_frame_period", 32'(cyc - last_fs), 32'(HT * VT));
          last_fs = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk_pixel);
    mon_en = 1'b1;
    apply_reset(2);
    // Two full frames, then stop inside the active area at hcnt=10, vcnt=3.
    run(2 * HT * VT + 3 * HT + 10);
    apply_reset(1);
    run(HT * VT + 30);
`ifdef VTG_TEST_PATTERN_EN
    pat_on = 1'b1;
    run(HT * VT + 7);
    pat_on = 1'b0;
    run(HT + 5);
`endif
    apply_reset(3);
    mon_en = 1'b0;
    check("queues_drained",
          32'(s0q_a.size() + s0q_b.size() + oq_a.size() + oq_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
